// File: rtl/mem_req_queue.sv
// Purpose: time-gated request queue between the trace parser and the DDR5 scheduler.
// Latency: an entry whose time has already been reached is enqueued one edge after acceptance.
// Backpressure: in_ready is low while an entry is staged; a full queue holds the stage until the scheduler pops.
//
// Ports:
//   clk, rst_n                          CPU clock, async active-low reset
//   in_valid/in_ready, in_time/core/opn/addr   parsed trace entry from the parser
//   out_valid/out_ready, out_time/core/opn/addr queue head to the scheduler
//   out_chan/bg/bank/col/row            DDR5 fields decoded from the head address
//   cur_time                            current CPU cycle
//   q_count, q_full                     queue occupancy
//   err_opn                             one-cycle pulse when an entry with an illegal opcode is dropped
// The address decode reads bits up to addr[33], so MEM_ADDR_WIDTH must be at least 34.

// Purpose: generic circular-buffer FIFO with wrap-around pointers.
// Latency: a write is visible at the read port after the write edge (no bypass).
// Backpressure: writes are taken when not full, or when full and a read happens in the same cycle.
module mem_req_queue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (cnt != '0);
    assign full   = (cnt == CW'(DEPTH));
    assign count  = cnt;
    assign do_rd  = rd_vld && rd_rdy;
    assign do_wr  = wr_vld && (!full || do_rd);
    // Storage is not reset; gating with rd_vld keeps the head at zero while empty.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Purpose: hold each parsed trace entry until the CPU cycle counter reaches its time, then queue it.
// Latency: accept at edge N, enqueue at edge N+1 if due; out_valid follows the enqueue edge.
// Backpressure: one staging register, so in_ready drops for at least one cycle per entry (1 entry / 2 cycles).
module mem_req_queue #(
    parameter int MEM_ADDR_WIDTH = 36,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int TIME_WIDTH     = 64,
    parameter int DEPTH          = 16,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TIME_WIDTH-1:0]     in_time,
    input  logic [CPU_CORE_WIDTH-1:0] in_core,
    input  logic [MEM_OPN_WIDTH-1:0]  in_opn,
    input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TIME_WIDTH-1:0]     out_time,
    output logic [CPU_CORE_WIDTH-1:0] out_core,
    output logic [MEM_OPN_WIDTH-1:0]  out_opn,
    output logic [MEM_ADDR_WIDTH-1:0] out_addr,
    output logic                      out_chan,
    output logic [2:0]                out_bg,
    output logic [1:0]                out_bank,
    output logic [9:0]                out_col,
    output logic [15:0]               out_row,
    output logic [TIME_WIDTH-1:0]     cur_time,
    output logic [CW-1:0]             q_count,
    output logic                      q_full,
    output logic                      err_opn
);
    typedef struct packed {
        logic [TIME_WIDTH-1:0]     t;
        logic [CPU_CORE_WIDTH-1:0] core;
        logic [MEM_OPN_WIDTH-1:0]  opn;
        logic [MEM_ADDR_WIDTH-1:0] addr;
    } entry_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state;
    state_t                state_nxt;
    entry_t                stage;
    entry_t                head;
    logic                  head_vld;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  opn_ok;
    logic                  eligible;
    logic                  skip;
    logic [TIME_WIDTH-1:0] time_r;
    logic [CW-1:0]         cnt;
    logic                  full;

    assign opn_ok   = (in_opn <= MEM_OPN_WIDTH'(2));
    // Out-of-order (older) stage times fall through this compare and go immediately.
    assign eligible = (stage.t <= time_r);
    assign pop      = head_vld && out_ready;
    // Nothing can happen until the staged time: jump straight to it rather than counting.
    // Extra bit keeps time_r+1 from wrapping at the saturation point.
    assign skip     = (state == S_WAIT) && (cnt == '0) && !pop &&
                      ({1'b0, stage.t} > ({1'b0, time_r} + 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (opn_ok) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A full queue may still take the stage when the head leaves this cycle.
                if (eligible && (!full || pop)) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage   <= '0;
            err_opn <= 1'b0;
        end else begin
            if (accept && opn_ok) stage <= {in_time, in_core, in_opn, in_addr};
            err_opn <= accept && !opn_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              time_r <= '0;
        else if (skip)           time_r <= stage.t;
        else if (time_r != '1)   time_r <= time_r + 1'b1;
    end

    mem_req_queue_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push),
        .wr_dat (stage),
        .rd_rdy (out_ready),
        .rd_vld (head_vld),
        .rd_dat (head),
        .count  (cnt),
        .full   (full)
    );

    assign out_valid = head_vld;
    assign out_time  = head.t;
    assign out_core  = head.core;
    assign out_opn   = head.opn;
    assign out_addr  = head.addr;
    assign out_chan  = head.addr[6];
    assign out_bg    = head.addr[9:7];
    assign out_bank  = head.addr[11:10];
    assign out_col   = {head.addr[17:12], head.addr[5:2]};
    assign out_row   = head.addr[33:18];
    assign cur_time  = time_r;
    assign q_count   = cnt;
    assign q_full    = full;
endmodule
